// File: rtl/mips_defs_pkg.sv
// Shared MIPS opcode/funct constants, field ranges and instruction-class decode.
// The forwarding controller reuses the same decode functions.
package mips_defs;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_JALR  = 6'h09;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  function automatic logic is_load(input logic [5:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_cal_i(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_LUI);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_REGIMM) || ((op >= OP_BEQ) && (op <= OP_BGTZ));
  endfunction

  function automatic logic is_jal(input logic [5:0] op);
    return op == OP_JAL;
  endfunction

  function automatic logic is_mdu_op(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && (fn >= F_MULT) && (fn <= F_DIVU);
  endfunction

  function automatic logic is_mdu_rw(input logic [5:0] op, input logic [5:0] fn);
    return ((op == OP_SPECIAL) && (fn >= F_MFHI) && (fn <= F_MTLO)) || is_mdu_op(op, fn);
  endfunction

  function automatic logic is_cal_r(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_SPECIAL) && !((fn == F_JR) || (fn == F_JALR) || (fn == F_MTHI) ||
                                   (fn == F_MTLO) || is_mdu_op(op, fn));
  endfunction

  function automatic logic tuse0_rs(input logic [5:0] op, input logic [5:0] fn);
    return is_branch(op) || ((op == OP_SPECIAL) && ((fn == F_JR) || (fn == F_JALR)));
  endfunction

  function automatic logic tuse0_rt(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic tuse1_rs(input logic [5:0] op, input logic [5:0] fn);
    return (is_cal_r(op, fn) && !((fn == F_SLL) || (fn == F_SRL) || (fn == F_SRA) ||
                                  (fn == F_MFHI) || (fn == F_MFLO))) ||
           (is_cal_i(op) && (op != OP_LUI)) || is_load(op) || is_store(op) ||
           is_mdu_op(op, fn) || ((op == OP_SPECIAL) && ((fn == F_MTHI) || (fn == F_MTLO)));
  endfunction

  function automatic logic tuse1_rt(input logic [5:0] op, input logic [5:0] fn);
    return (is_cal_r(op, fn) && !((fn == F_MFHI) || (fn == F_MFLO))) || is_mdu_op(op, fn);
  endfunction

  // jal/jalr deliberately report no destination: forwarding covers their link write.
  function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] rt, input logic [4:0] rd);
    if (is_cal_r(op, fn)) begin
      return rd;
    end else if (is_cal_i(op) || is_load(op)) begin
      return rt;
    end else begin
      return 5'd0;
    end
  endfunction

  function automatic logic reads_in_d(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] r);
    return (tuse0_rs(op, fn) && (rs == r)) || (tuse0_rt(op) && (rt == r));
  endfunction

  function automatic logic reads_by_e(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] r);
    return reads_in_d(op, fn, rs, rt, r) ||
           (tuse1_rs(op, fn) && (rs == r)) || (tuse1_rt(op, fn) && (rt == r));
  endfunction

endpackage

// File: rtl/pipe_ir_stall_mdu_busy_ctr.sv
// Multiply/divide occupancy counter: loaded when an mdu op sits in E,
// then counts down; mdu_busy mirrors (counter != 0) as a register.
module mdu_busy_ctr #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic mdu_busy
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next counter value: reload on a new mdu op, otherwise count down to zero.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (start) begin
      if (is_div) begin
        cnt_nxt_s = CNT_W'(DIV_CYCLES);
      end else begin
        cnt_nxt_s = CNT_W'(MULT_CYCLES);
      end
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_nxt_s = cnt_r - CNT_W'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and busy flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r    <= {CNT_W{1'b0}};
      mdu_busy <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      mdu_busy <= (cnt_nxt_s != {CNT_W{1'b0}});
    end
  end

endmodule

// File: rtl/pipe_ir_stall.sv
// D/E/M/W instruction registers with Tuse/Tnew stall detection and
// multiply/divide occupancy tracking.
module pipe_ir_stall
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_F,
  output logic [31:0] IR_D,
  output logic [31:0] IR_E,
  output logic [31:0] IR_M,
  output logic [31:0] IR_W,
  output logic        stall,
  output logic        mdu_busy
);

  logic [5:0] op_d_s, fn_d_s, op_e_s, fn_e_s, op_m_s, fn_m_s;
  logic [4:0] rs_d_s, rt_d_s, dest_e_s, dest_m_s;
  logic       hz_load_e_s, hz_cal_e_s, hz_load_m_s, hz_mdu_s;
  logic       mdu_start_s, mdu_div_s;

  // Field extraction and hazard rules; a zero destination never stalls.
  always_comb begin
    op_d_s   = IR_D[OP_HI:OP_LO];
    fn_d_s   = IR_D[FUNCT_HI:FUNCT_LO];
    rs_d_s   = IR_D[RS_HI:RS_LO];
    rt_d_s   = IR_D[RT_HI:RT_LO];
    op_e_s   = IR_E[OP_HI:OP_LO];
    fn_e_s   = IR_E[FUNCT_HI:FUNCT_LO];
    op_m_s   = IR_M[OP_HI:OP_LO];
    fn_m_s   = IR_M[FUNCT_HI:FUNCT_LO];
    dest_e_s = dest_of(op_e_s, fn_e_s, IR_E[RT_HI:RT_LO], IR_E[RD_HI:RD_LO]);
    dest_m_s = dest_of(op_m_s, fn_m_s, IR_M[RT_HI:RT_LO], IR_M[RD_HI:RD_LO]);

    hz_load_e_s = is_load(op_e_s) && (dest_e_s != 5'd0) &&
                  reads_by_e(op_d_s, fn_d_s, rs_d_s, rt_d_s, dest_e_s);
    hz_cal_e_s  = (is_cal_r(op_e_s, fn_e_s) || is_cal_i(op_e_s)) && (dest_e_s != 5'd0) &&
                  reads_in_d(op_d_s, fn_d_s, rs_d_s, rt_d_s, dest_e_s);
    hz_load_m_s = is_load(op_m_s) && (dest_m_s != 5'd0) &&
                  reads_in_d(op_d_s, fn_d_s, rs_d_s, rt_d_s, dest_m_s);
    hz_mdu_s    = is_mdu_rw(op_d_s, fn_d_s) && (mdu_busy || is_mdu_op(op_e_s, fn_e_s));

    stall       = hz_load_e_s || hz_cal_e_s || hz_load_m_s || hz_mdu_s;
    mdu_start_s = is_mdu_op(op_e_s, fn_e_s);
    mdu_div_s   = (fn_e_s == F_DIV) || (fn_e_s == F_DIVU);
  end

  // Pipeline advance; on stall D holds and a nop bubble enters E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IR_D <= 32'd0;
      IR_E <= 32'd0;
      IR_M <= 32'd0;
      IR_W <= 32'd0;
    end else if (stall) begin
      IR_D <= IR_D;
      IR_E <= 32'd0;
      IR_M <= IR_E;
      IR_W <= IR_M;
    end else begin
      IR_D <= IR_F;
      IR_E <= IR_D;
      IR_M <= IR_E;
      IR_W <= IR_M;
    end
  end

  mdu_busy_ctr #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_busy_ctr (
    .clk     (clk),
    .reset   (reset),
    .start   (mdu_start_s),
    .is_div  (mdu_div_s),
    .mdu_busy(mdu_busy)
  );

endmodule

// File: tb/tb_pipe_ir_stall.sv
// Scoreboard bench: a Tnew/Tuse reference model predicts each cycle's outputs,
// a negedge monitor compares them against the DUT.
module tb_pipe_ir_stall;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_F;
  logic [31:0] IR_D, IR_E, IR_M, IR_W;
  logic        stall, mdu_busy;

  pipe_ir_stall #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .IR_F(IR_F), .IR_D(IR_D), .IR_E(IR_E),
    .IR_M(IR_M), .IR_W(IR_W), .stall(stall), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d, e, m, w;
    logic        stall, busy;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          dut_stalls = 0;

  // reference model state: m_ir[0..3] = D,E,M,W; MDU free from cycle 'ready'
  logic [31:0] m_ir[4];
  logic [31:0] m_f;
  bit          m_stall;
  int          cyc, ready;

  localparam logic [31:0] NOP = 32'h0000_0000;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic bit b_load(input logic [31:0] i);
    return i[31:26] inside {[6'h20:6'h25]};
  endfunction

  function automatic bit b_mduop(input logic [31:0] i);
    return i[31:26] == 6'h00 && i[5:0] inside {[6'h18:6'h1B]};
  endfunction

  function automatic bit b_calr(input logic [31:0] i);
    return i[31:26] == 6'h00 && !(i[5:0] inside {6'h08, 6'h09, 6'h11, 6'h13, [6'h18:6'h1B]});
  endfunction

  function automatic logic [4:0] b_dest(input logic [31:0] i);
    if (b_calr(i)) return i[15:11];
    if (b_load(i) || i[31:26] inside {[6'h08:6'h0F]}) return i[20:16];
    return 5'd0;
  endfunction

  // result available this many stages after the current one (E=1, M=2)
  function automatic int b_tnew(input logic [31:0] i, input int stage);
    if (b_load(i)) return 3 - stage;
    if (b_calr(i) || i[31:26] inside {[6'h08:6'h0F]}) return 2 - stage;
    return 0;
  endfunction

  // stage index (0=D, 1=E) at which instruction i first needs register r; 9 = never
  function automatic int b_need(input logic [31:0] i, input logic [4:0] r);
    logic [5:0] op, fn;
    bit rs0, rt0, rs1, rt1;
    op  = i[31:26];
    fn  = i[5:0];
    rs0 = op == 6'h01 || op inside {[6'h04:6'h07]} || (op == 6'h00 && fn inside {6'h08, 6'h09});
    rt0 = op inside {6'h04, 6'h05};
    rs1 = (b_calr(i) && !(fn inside {6'h00, 6'h02, 6'h03, 6'h10, 6'h12})) ||
          op inside {[6'h08:6'h0E], [6'h20:6'h25], [6'h28:6'h2B]} || b_mduop(i) ||
          (op == 6'h00 && fn inside {6'h11, 6'h13});
    rt1 = (b_calr(i) && !(fn inside {6'h10, 6'h12})) || b_mduop(i);
    if ((rs0 && i[25:21] == r) || (rt0 && i[20:16] == r)) return 0;
    if ((rs1 && i[25:21] == r) || (rt1 && i[20:16] == r)) return 1;
    return 9;
  endfunction

  function automatic bit model_stall();
    bit st;
    logic [4:0] dst;
    st = 1'b0;
    for (int s = 1; s <= 2; s++) begin
      dst = b_dest(m_ir[s]);
      if (dst != 5'd0 && b_tnew(m_ir[s], s) > b_need(m_ir[0], dst)) st = 1'b1;
    end
    if (m_ir[0][31:26] == 6'h00 && m_ir[0][5:0] inside {[6'h10:6'h13], [6'h18:6'h1B]} &&
        (cyc < ready || b_mduop(m_ir[1]))) st = 1'b1;
    return st;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) m_ir[s] = NOP;
    m_f = NOP; m_stall = 1'b0; cyc = 0; ready = 0;
  endtask

  // one clock: advance the model over the edge, drive the new fetch, push expectation
  task automatic step(input logic [31:0] instr);
    exp_t e;
    @(posedge clk); #1;
    if (b_mduop(m_ir[1])) ready = cyc + 1 + ((m_ir[1][5:0] inside {6'h1A, 6'h1B}) ? 10 : 5);
    m_ir[3] = m_ir[2];
    m_ir[2] = m_ir[1];
    if (m_stall) m_ir[1] = NOP;
    else begin m_ir[1] = m_ir[0]; m_ir[0] = m_f; end
    cyc++;
    IR_F = instr;
    m_f = instr;
    m_stall = model_stall();
    e.d = m_ir[0]; e.e = m_ir[1]; e.m = m_ir[2]; e.w = m_ir[3];
    e.stall = m_stall; e.busy = (cyc < ready);
    sb_q.push_back(e);
  endtask

  // present one instruction, holding it in F while the model predicts a stall
  task automatic feed(input logic [31:0] instr);
    int guard;
    guard = 0;
    step(instr);
    while (m_stall && guard < 20) begin step(instr); guard++; end
    if (m_stall) begin
      n_cmp++; n_err++;
      $display("FAIL hold_bound: stall still %0d after %0d cycles, required 0", m_stall, guard);
    end
  endtask

  task automatic run_seq(input string nm, input logic [31:0] prog[$], input int exp_stalls);
    int base;
    base = dut_stalls;
    foreach (prog[k]) feed(prog[k]);
    repeat (12) feed(NOP);
    @(negedge clk); #1;
    chk({nm, "_stalls"}, 32'(dut_stalls - base), 32'(exp_stalls));
  endtask

  task automatic do_reset(input bit chk_busy);
    @(negedge clk); #1;
    if (chk_busy) chk("busy_before_reset", {31'd0, mdu_busy}, 32'd1);
    reset = 1'b1; IR_F = NOP;
    #1;
    chk("rst_ir_d", IR_D, 32'd0);
    chk("rst_ir_e", IR_E, 32'd0);
    chk("rst_ir_m", IR_M, 32'd0);
    chk("rst_ir_w", IR_W, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, mdu_busy}, 32'd0);
    sb_q.delete();
    model_reset();
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    int a, b, c;
    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    case ($urandom_range(0, 15))
      0:  return r_type(a, b, c, 6'h21);
      1:  return r_type(a, b, c, 6'h23);
      2:  return r_type(0, b, c, 6'h00);
      3:  return i_type(6'h0D, a, b, 16'h00ff);
      4:  return i_type(6'h0F, 0, b, 16'h1234);
      5:  return i_type(6'h23, a, b, 16'h0004);
      6:  return i_type(6'h2B, a, b, 16'h0008);
      7:  return i_type(6'h04, a, b, 16'h0002);
      8:  return i_type(6'h05, a, b, 16'h0002);
      9:  return i_type(6'h07, a, 0, 16'h0002);
      10: return ($urandom_range(0, 1) == 0) ? r_type(a, 0, 0, 6'h08) : r_type(a, 0, 31, 6'h09);
      11: return r_type(a, b, 0, 6'(6'h18 + $urandom_range(0, 3)));
      12: return r_type(0, 0, c, ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12);
      13: return r_type(a, 0, 0, ($urandom_range(0, 1) == 0) ? 6'h11 : 6'h13);
      14: return {6'h03, 26'h0000040};
      default: return NOP;
    endcase
  endfunction

  // monitor: compare every presented output set against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("ir_d", IR_D, mon_e.d);
      chk("ir_e", IR_E, mon_e.e);
      chk("ir_m", IR_M, mon_e.m);
      chk("ir_w", IR_W, mon_e.w);
      chk("stall", {31'd0, stall}, {31'd0, mon_e.stall});
      chk("mdu_busy", {31'd0, mdu_busy}, {31'd0, mon_e.busy});
      dut_stalls += int'(stall);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] prog[$];
    reset = 1'b1;
    IR_F  = NOP;
    model_reset();
    do_reset(1'b0);

    prog = {i_type(6'h23, 1, 3, 16'h0000), r_type(3, 2, 4, 6'h21)};
    run_seq("load_use", prog, 1);
    prog = {r_type(1, 2, 5, 6'h21), i_type(6'h04, 5, 0, 16'h0004)};
    run_seq("alu_branch", prog, 1);
    prog = {i_type(6'h23, 1, 5, 16'h0000), i_type(6'h04, 5, 6, 16'h0004)};
    run_seq("load_branch", prog, 2);
    prog = {r_type(1, 2, 0, 6'h18), r_type(0, 0, 3, 6'h12)};
    run_seq("mult_mflo", prog, 6);
    prog = {i_type(6'h23, 1, 0, 16'h0000), r_type(0, 0, 4, 6'h21),
            i_type(6'h23, 1, 3, 16'h0000), i_type(6'h2B, 1, 3, 16'h0004)};
    run_seq("no_false", prog, 0);

    step(r_type(1, 2, 0, 6'h1A));
    repeat (7) step(NOP);
    do_reset(1'b1);
    prog = {r_type(0, 0, 3, 6'h12)};
    run_seq("post_reset_mflo", prog, 0);

    repeat (300) feed(rand_instr());
    repeat (12) feed(NOP);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
